// File: rtl/test_mode_pkg.sv
// Shared types and constants for the test-mode stimulus sequencer.
package test_mode_pkg;

  localparam int TM_CLEAR_CYC = 2;
  localparam int TM_OUT_W     = 4;

  typedef enum logic [2:0] {
    TM_IDLE    = 3'd0,
    TM_CLEAR   = 3'd1,
    TM_DRIVE   = 3'd2,
    TM_SETTLE  = 3'd3,
    TM_CAPTURE = 3'd4,
    TM_DONE    = 3'd5
  } tm_state_t;

  function automatic int tm_max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/test_mode_pat_shift.sv
// Pair of load/shift-right pattern registers; the current LSBs feed the datapath serially.
module test_mode_pat_shift #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [PAT_W-1:0] i_pat_a,
  input  logic [PAT_W-1:0] i_pat_b,
  output logic             o_bit_a,
  output logic             o_bit_b
);

  logic [PAT_W-1:0] r_a;
  logic [PAT_W-1:0] r_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_load) begin
      r_a <= i_pat_a;
      r_b <= i_pat_b;
    end else if (i_en) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
    end
  end

  assign o_bit_a = r_a[0];
  assign o_bit_b = r_b[0];

endmodule

// File: rtl/test_mode_seq.sv
// Sequencer that resets the test-mode datapath, shifts two patterns in, settles,
// then samples and compares the datapath output.
module test_mode_seq
  import test_mode_pkg::*;
#(
  parameter int PAT_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PAT_W-1:0]    pat_a,
  input  logic [PAT_W-1:0]    pat_b,
  input  logic [TM_OUT_W-1:0] exp_out,
  input  logic [TM_OUT_W-1:0] dut_out,
  output logic                dut_a,
  output logic                dut_b,
  output logic                dut_reset,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [TM_OUT_W-1:0] captured
);

  localparam int CW = $clog2(tm_max3(PAT_W, SETTLE_CYC, 2)) + 1;
  localparam logic [CW-1:0] LD_CLEAR  = CW'(TM_CLEAR_CYC - 1);
  localparam logic [CW-1:0] LD_DRIVE  = CW'(PAT_W - 1);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYC - 1);

  tm_state_t             r_state;
  logic [CW-1:0]         r_cnt;
  logic [TM_OUT_W-1:0]   r_exp;
  logic                  r_pass;
  logic [TM_OUT_W-1:0]   r_captured;
  logic                  w_load;
  logic                  w_shift_en;
  logic                  w_bit_a;
  logic                  w_bit_b;
  logic                  w_cnt_zero;

  assign w_load     = (r_state == TM_IDLE) && start && !abort;
  assign w_shift_en = (r_state == TM_DRIVE) && !abort;
  assign w_cnt_zero = (r_cnt == '0);

  test_mode_pat_shift #(.PAT_W(PAT_W)) u_pat_shift (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_en    (w_shift_en),
    .i_pat_a (pat_a),
    .i_pat_b (pat_b),
    .o_bit_a (w_bit_a),
    .o_bit_b (w_bit_b)
  );

  // abort wins over every transition; an aborted run never touches pass/captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= TM_IDLE;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_pass     <= 1'b0;
      r_captured <= '0;
    end else if (abort) begin
      r_state <= TM_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        TM_IDLE: begin
          if (start) begin
            r_state <= TM_CLEAR;
            r_cnt   <= LD_CLEAR;
            r_exp   <= exp_out;
          end
        end
        TM_CLEAR: begin
          if (w_cnt_zero) begin
            r_state <= TM_DRIVE;
            r_cnt   <= LD_DRIVE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        TM_DRIVE: begin
          if (w_cnt_zero) begin
            r_state <= TM_SETTLE;
            r_cnt   <= LD_SETTLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        TM_SETTLE: begin
          if (w_cnt_zero) begin
            r_state <= TM_CAPTURE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        TM_CAPTURE: begin
          r_captured <= dut_out;
          r_pass     <= (dut_out == r_exp);
          r_state    <= TM_DONE;
        end
        TM_DONE: r_state <= TM_IDLE;
        default: r_state <= TM_IDLE;
      endcase
    end
  end

  // Combinational so the datapath stays in reset while the sequencer is in reset.
  assign dut_reset = reset | (r_state == TM_CLEAR);
  assign dut_a     = (r_state == TM_DRIVE) & w_bit_a;
  assign dut_b     = (r_state == TM_DRIVE) & w_bit_b;
  assign busy      = (r_state != TM_IDLE);
  assign done      = (r_state == TM_DONE);
  assign pass      = r_pass;
  assign captured  = r_captured;

endmodule

// File: tb/tb_test_mode_seq.sv
// Directed bench for test_mode_seq driving a small accumulating datapath model
// (out += a + b each cycle, cleared by dut_reset).
module tb_test_mode_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pat_a;
  logic [7:0] pat_b;
  logic [3:0] exp_out;
  logic [3:0] dut_out;
  logic       dut_a;
  logic       dut_b;
  logic       dut_reset;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] captured;

  int total = 0;
  int bad   = 0;

  test_mode_seq #(.PAT_W(8), .SETTLE_CYC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .pat_a     (pat_a),
    .pat_b     (pat_b),
    .exp_out   (exp_out),
    .dut_out   (dut_out),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_reset (dut_reset),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .captured  (captured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge dut_reset) begin
    if (dut_reset) dut_out <= 4'h0;
    else           dut_out <= dut_out + {3'b000, dut_a} + {3'b000, dut_b};
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Launch a run and follow it until done (bounded); returns done cycle and busy count.
  task automatic launch_and_wait(input logic [7:0] pa, input logic [7:0] pb, input logic [3:0] ex,
                                 output int dcyc, output int bcnt);
    pat_a = pa; pat_b = pb; exp_out = ex; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcyc = 0;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) bcnt++;
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int dcyc;
    int bcnt;
    int dcnt;
    logic [7:0] ref_a;
    logic [7:0] ref_b;
    ref_a = 8'hA5;
    ref_b = 8'h3C;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pat_a = 8'h00; pat_b = 8'h00; exp_out = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_captured", captured, 0);
    chk("rst_dut_a", dut_a, 0);
    chk("rst_dut_b", dut_b, 0);
    chk("rst_dut_reset", dut_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_dut_reset", dut_reset, 0);

    // zero patterns, matching expectation
    launch_and_wait(8'h00, 8'h00, 4'h0, dcyc, bcnt);
    chk("r1_done_cycle", dcyc, 16);
    chk("r1_busy_cycles", bcnt, 16);
    chk("r1_pass", pass, 1);
    chk("r1_captured", captured, 0);
    @(negedge clk);
    chk("r1_done_one_cycle", done, 0);
    chk("r1_idle_busy", busy, 0);

    // zero patterns, wrong expectation
    launch_and_wait(8'h00, 8'h00, 4'hF, dcyc, bcnt);
    chk("r2_done_cycle", dcyc, 16);
    chk("r2_pass", pass, 0);
    chk("r2_captured", captured, 0);
    @(negedge clk);

    // A5/3C bit trace; restart attempt and pat_a change in DRIVE cycle 3 are ignored
    pat_a = ref_a; pat_b = ref_b; exp_out = 4'h8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("r3_dut_a_c%0d", c), dut_a, (c >= 3 && c <= 10) ? int'(ref_a[c-3]) : 0);
      chk($sformatf("r3_dut_b_c%0d", c), dut_b, (c >= 3 && c <= 10) ? int'(ref_b[c-3]) : 0);
      chk($sformatf("r3_dut_reset_c%0d", c), dut_reset, (c <= 2) ? 1 : 0);
      chk($sformatf("r3_done_c%0d", c), done, (c == 16) ? 1 : 0);
      if (c == 6) begin
        start = 1'b1;
        pat_a = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (c < 16) @(negedge clk);
    end
    chk("r3_pass", pass, 1);
    chk("r3_captured", captured, 8);
    @(negedge clk);
    chk("r3_no_restart", busy, 0);

    // abort in SETTLE after a passing run
    pat_a = ref_a; pat_b = ref_b; exp_out = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("r4_in_settle_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("r4_abort_busy", busy, 0);
    chk("r4_abort_done", done, 0);
    chk("r4_abort_pass", pass, 1);
    chk("r4_abort_captured", captured, 8);
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("r4_no_done_pulse", dcnt, 0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("r4_abort_start_busy", busy, 0);
    @(negedge clk);
    chk("r4_abort_start_busy2", busy, 0);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);

    // reset in DRIVE cycle 4
    pat_a = 8'h00; pat_b = 8'h00; exp_out = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("r5_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("r5_rst_busy", busy, 0);
    chk("r5_rst_done", done, 0);
    chk("r5_rst_pass", pass, 0);
    chk("r5_rst_captured", captured, 0);
    chk("r5_rst_dut_reset", dut_reset, 1);
    @(negedge clk);
    chk("r5_rst_hold_dut_reset", dut_reset, 1);
    chk("r5_rst_hold_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    launch_and_wait(8'h00, 8'h00, 4'h0, dcyc, bcnt);
    chk("r5_done_cycle", dcyc, 16);
    chk("r5_pass", pass, 1);
    chk("r5_captured", captured, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/test_mode_seq.md
# test_mode_seq

Self-checking stimulus sequencer for the 2x2 test-mode low-density datapath (serial inputs `a`/`b`, 4-bit registered `out`). On each `start` it resets the datapath and shifts two PAT_W-bit patterns into it serially. It then waits a settle window, samples `out`, compares it against an expected value, and reports pass/fail. It sits between a bench/host controller and one datapath instance and owns that instance's `a`, `b` and `reset` pins.

## Interface
- PAT_W, 8, pattern length in bits (one bit per DRIVE cycle); legal range ≥1
- SETTLE_CYC, 4, cycles with `a`=`b`=0 between the last driven bit and capture; legal range ≥1
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  launch request; sampled only in IDLE
- abort  in  1  return to IDLE from any state without a done pulse
- pat_a  in  PAT_W  pattern for datapath `a`, sent LSB first
- pat_b  in  PAT_W  pattern for datapath `b`, sent LSB first
- exp_out  in  4  expected datapath `out` at capture
- dut_out  in  4  datapath `out`
- dut_a  out  1  to datapath `a`
- dut_b  out  1  to datapath `b`
- dut_reset  out  1  to datapath `reset`
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- pass  out  1  compare result of last completed run
- captured  out  4  `dut_out` sampled at last CAPTURE

## Operation
- States: IDLE, CLEAR, DRIVE, SETTLE, CAPTURE, DONE.
- IDLE:
  - On `start` && !`abort`: latch `pat_a`, `pat_b` and `exp_out` into internal registers, load cycle counter, go to CLEAR.
  - Later input changes are ignored until the next launch.
- CLEAR: 2 cycles.
  - `dut_reset`=1, `dut_a`=`dut_b`=0.
  - Then go to DRIVE.
- DRIVE: PAT_W cycles.
  - In DRIVE cycle i (i=0..PAT_W-1), `dut_a`=pat_a_q[i] and `dut_b`=pat_b_q[i].
  - Then go to SETTLE.
- SETTLE: SETTLE_CYC cycles with `dut_a`=`dut_b`=0.
- CAPTURE: 1 cycle.
  - On its closing edge, `captured`<=`dut_out` and `pass`<=(`dut_out`==exp_q).
  - Go to DONE.
- DONE: 1 cycle with `done`=1; then go to IDLE.
- `dut_reset` = `reset` OR (state==CLEAR). This is combinational so the datapath is held in reset while the sequencer is in reset.
- `abort`:
  - Has priority over every transition, including start in IDLE.
  - Next state is IDLE; `done` is not pulsed.
  - `pass` and `captured` keep the values from the last completed run.
- `start` while busy: ignored, with no queuing.
- `start` held high across DONE→IDLE: launches a new run on the first IDLE cycle.
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, `captured`=4'h0, `dut_a`=`dut_b`=0, `dut_reset`=1 (while reset is high).
- Reset mid-run: immediate return to IDLE, all outputs at their reset values, no done pulse.

## Timing
- All outputs except `dut_reset` are registered or decoded from registered state. There is no combinational path from `start`, `abort`, `pat_*` or `exp_out` to any output.
- Cycle numbering: edge E0 is the edge that samples `start` in IDLE.
  - CLEAR: cycles 1–2.
  - DRIVE: cycles 3 to 2+PAT_W.
  - SETTLE: the next SETTLE_CYC cycles.
  - CAPTURE: cycle PAT_W+SETTLE_CYC+3.
  - DONE: cycle PAT_W+SETTLE_CYC+4.
- With the defaults, `done` is high in cycle 16 after E0, and `busy` is high for 16 cycles.
- `pass` and `captured` update on the same edge that raises `done`. They hold until the next CAPTURE or reset.
- Back-to-back runs: minimum launch spacing is PAT_W+SETTLE_CYC+5 cycles (one IDLE cycle between runs).
- Cycle counter width: $clog2(max(PAT_W, SETTLE_CYC, 2))+1. It reloads on each state entry and counts down to zero.

## Structure
- Package `test_mode_pkg`:
  - State enum `tm_state_t` (IDLE, CLEAR, DRIVE, SETTLE, CAPTURE, DONE).
  - `TM_CLEAR_CYC`=2.
  - `TM_OUT_W`=4.
- Sub-module `test_mode_pat_shift`:
  - Two PAT_W-bit load/shift-right registers with a shared load/enable.
  - Outputs are the current LSBs.
  - Instantiated once; the FSM drives load on launch and enable during DRIVE.
- The FSM, counter and compare live in the top module.

## Test plan
- Reset, then `start` with `pat_a`=`pat_b`=8'h00 and `exp_out`=4'h0 against a real datapath → `done` in cycle 16 after E0, `pass`=1, `captured`=4'h0.
- Same run with `exp_out`=4'hF → `pass`=0, `captured`=4'h0, `done` still in cycle 16.
- `pat_a`=8'hA5, `pat_b`=8'h3C → in DRIVE cycles 0–7, `dut_a`=1,0,1,0,0,1,0,1 and `dut_b`=0,0,1,1,1,1,0,0; `dut_a`/`dut_b`=0 in CLEAR and SETTLE; `dut_reset` high for exactly cycles 1–2.
- Pulse `start` again in DRIVE cycle 3, and change `pat_a` mid-run → no restart; run completes with the originally latched patterns.
- `abort` in SETTLE after a prior passing run → IDLE next cycle, `busy`=0, no `done`, `pass`=1 and `captured` unchanged. Also `abort`+`start` together in IDLE → stays IDLE.
- Assert `reset` in DRIVE cycle 4 → immediately IDLE, `busy`=`done`=`pass`=0, `captured`=0, `dut_reset`=1 while reset is high. After reset releases, a fresh `start` completes normally.
